// File: rtl/sha_sigma_pipe_if.sv
// Request/response bundle for sha_sigma_pipe: one request channel and one
// result channel, each with a valid/ready handshake and an opaque tag.
interface sha_sigma_pipe_if #(
    parameter int WIDTH = 32,
    parameter int TAG_W = 4
);
    logic             in_valid;
    logic             in_ready;
    logic [2:0]       in_op;
    logic [WIDTH-1:0] in_x;
    logic [WIDTH-1:0] in_y;
    logic [WIDTH-1:0] in_z;
    logic [TAG_W-1:0] in_tag;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_data;
    logic [TAG_W-1:0] out_tag;
    logic             out_err;

    // The pipeline side: consumes requests, produces results.
    modport slave (
        input  in_valid, in_op, in_x, in_y, in_z, in_tag, out_ready,
        output in_ready, out_valid, out_data, out_tag, out_err
    );

    // The round-control side: issues requests, consumes results.
    modport master (
        output in_valid, in_op, in_x, in_y, in_z, in_tag, out_ready,
        input  in_ready, out_valid, out_data, out_tag, out_err
    );
endinterface

// File: rtl/sha_sigma_pipe.sv
// Two-stage elastic pipeline evaluating the SHA-2 Sigma/sigma functions for
// 32- or 64-bit words. Define SHA_SIGMA_CHMAJ_EN to add Ch (op 4) and Maj (op 5).
module sha_sigma_pipe #(
    parameter int WIDTH = 32,
    parameter int TAG_W = 4
) (
    input  logic              clk,
    input  logic              rst,
    sha_sigma_pipe_if.slave   bus
);

    if (WIDTH != 32 && WIDTH != 64) begin : g_bad_width
        $error("sha_sigma_pipe: WIDTH must be 32 or 64");
    end
    if (TAG_W < 1) begin : g_bad_tag
        $error("sha_sigma_pipe: TAG_W must be at least 1");
    end

    localparam int BS0_A = (WIDTH == 64) ? 28 : 2;
    localparam int BS0_B = (WIDTH == 64) ? 34 : 13;
    localparam int BS0_C = (WIDTH == 64) ? 39 : 22;
    localparam int BS1_A = (WIDTH == 64) ? 14 : 6;
    localparam int BS1_B = (WIDTH == 64) ? 18 : 11;
    localparam int BS1_C = (WIDTH == 64) ? 41 : 25;
    localparam int SS0_A = (WIDTH == 64) ? 1  : 7;
    localparam int SS0_B = (WIDTH == 64) ? 8  : 18;
    localparam int SS0_S = (WIDTH == 64) ? 7  : 3;
    localparam int SS1_A = (WIDTH == 64) ? 19 : 17;
    localparam int SS1_B = (WIDTH == 64) ? 61 : 19;
    localparam int SS1_S = (WIDTH == 64) ? 6  : 10;

    function automatic logic [WIDTH-1:0] rotr(input logic [WIDTH-1:0] v, input int n);
        return (v >> n) | (v << (WIDTH - n));
    endfunction

    function automatic logic [WIDTH-1:0] big_sigma(input logic [WIDTH-1:0] v,
                                                   input int a, input int b, input int c);
        return rotr(v, a) ^ rotr(v, b) ^ rotr(v, c);
    endfunction

    function automatic logic [WIDTH-1:0] small_sigma(input logic [WIDTH-1:0] v,
                                                     input int a, input int b, input int s);
        return rotr(v, a) ^ rotr(v, b) ^ (v >> s);
    endfunction

    logic             r_v1;
    logic [2:0]       r_s1_op;
    logic [WIDTH-1:0] r_s1_x;
    logic [TAG_W-1:0] r_s1_tag;
`ifdef SHA_SIGMA_CHMAJ_EN
    logic [WIDTH-1:0] r_s1_y;
    logic [WIDTH-1:0] r_s1_z;
`endif
    logic             r_v2;
    logic [WIDTH-1:0] r_s2_data;
    logic [TAG_W-1:0] r_s2_tag;
    logic             r_s2_err;

    logic             w_r1;
    logic             w_r2;
    logic [WIDTH-1:0] w_fn_data;
    logic             w_fn_err;

    // A stage may load when it is empty or the stage after it is draining.
    assign w_r2 = !r_v2 || bus.out_ready;
    assign w_r1 = !r_v1 || w_r2;

    assign bus.in_ready  = w_r1;
    assign bus.out_valid = r_v2;
    assign bus.out_data  = r_s2_data;
    assign bus.out_tag   = r_s2_tag;
    assign bus.out_err   = r_s2_err;

    // Stage 1: capture the request operands.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_v1     <= 1'b0;
            r_s1_op  <= 3'd0;
            r_s1_x   <= '0;
            r_s1_tag <= '0;
`ifdef SHA_SIGMA_CHMAJ_EN
            r_s1_y   <= '0;
            r_s1_z   <= '0;
`endif
        end else if (w_r1) begin
            r_v1 <= bus.in_valid;
            if (bus.in_valid) begin
                r_s1_op  <= bus.in_op;
                r_s1_x   <= bus.in_x;
                r_s1_tag <= bus.in_tag;
`ifdef SHA_SIGMA_CHMAJ_EN
                r_s1_y   <= bus.in_y;
                r_s1_z   <= bus.in_z;
`endif
            end
        end
    end

    // Function evaluation from the stage-1 registers.
    always_comb begin
        w_fn_data = '0;
        w_fn_err  = 1'b0;
        case (r_s1_op)
            3'd0:    w_fn_data = big_sigma(r_s1_x, BS0_A, BS0_B, BS0_C);
            3'd1:    w_fn_data = big_sigma(r_s1_x, BS1_A, BS1_B, BS1_C);
            3'd2:    w_fn_data = small_sigma(r_s1_x, SS0_A, SS0_B, SS0_S);
            3'd3:    w_fn_data = small_sigma(r_s1_x, SS1_A, SS1_B, SS1_S);
`ifdef SHA_SIGMA_CHMAJ_EN
            3'd4:    w_fn_data = (r_s1_x & r_s1_y) ^ (~r_s1_x & r_s1_z);
            3'd5:    w_fn_data = (r_s1_x & r_s1_y) ^ (r_s1_x & r_s1_z) ^ (r_s1_y & r_s1_z);
`endif
            default: begin
                w_fn_data = '0;
                w_fn_err  = 1'b1;
            end
        endcase
    end

    // Stage 2: register the result; it holds while the consumer stalls.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_v2      <= 1'b0;
            r_s2_data <= '0;
            r_s2_tag  <= '0;
            r_s2_err  <= 1'b0;
        end else if (w_r2) begin
            r_v2 <= r_v1;
            if (r_v1) begin
                r_s2_data <= w_fn_data;
                r_s2_tag  <= r_s1_tag;
                r_s2_err  <= w_fn_err;
            end
        end
    end

endmodule
